arb_rr_hold: RTL
================

Name: arb_rr_hold

Overview:
- Round-robin arbiter that shares one downstream resource among REQ_NUM requesters.
- A granted requester holds the grant over multiple cycles until it releases. Release is by dropping req, by pulsing done, or by a forced preemption once MAX_HOLD cycles have elapsed.
- Sits in front of the shared resource as the fairness-controlled counterpart to the fixed-priority arbiters: it is a registered grant generator with a tenure counter.

Parameters:
- REQ_NUM, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 16, maximum tenure in cycles before forced release; 0 = unlimited (timeout disabled).
- ID_W, $clog2(REQ_NUM), width of grant_id; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  REQ_NUM  request level per requester; held high while the requester wants or uses the resource.
- done  input  REQ_NUM  one-cycle release pulse; only the bit of the current holder is honoured.
- grant  output  REQ_NUM  registered one-hot grant, or all-zero.
- grant_valid  output  1  high when grant != 0.
- grant_id  output  ID_W  index of the holder; 0 when grant_valid = 0.
- timeout  output  1  one-cycle pulse in the cycle after a forced release.

Behaviour:
- One clock, one synchronous active-high reset. All outputs are registered.
- Reset (rst=1 at an edge): grant=0, grant_valid=0, grant_id=0, timeout=0, hold counter=0, state=IDLE, rr pointer=0. req[0] therefore wins the first arbitration after reset. Reset mid-tenure drops the grant at that same edge; there is no completion of the tenure.
- State machine has two states:
  - IDLE: grant=0. At an edge with any req bit high, grant the winner and go to BUSY. Otherwise stay in IDLE.
  - BUSY: the holder h owns the resource. Release condition R is any of:
    - req[h]=0
    - done[h]=1
    - timeout enabled and hold counter == MAX_HOLD-1
  - On R at an edge, re-arbitrate in the same edge among current req bits:
    - The holder is a candidate only if req[h]=1 and the release was not caused by done[h].
    - If a winner exists: stay in BUSY with the new grant. Back-to-back handover has no idle bubble.
    - Otherwise: go to IDLE.
- Winner selection: search req starting at index ptr, ascending, wrapping modulo REQ_NUM. The first set bit wins.
  - On every new grant to index w: ptr <= (w+1) mod REQ_NUM.
  - The holder is thus searched last, so any other pending requester beats it.
- Latency: req[i] rising in the cycle before edge k, with the resource free and i the winner, gives grant[i]=1 from edge k (1 cycle).
- Hold counter:
  - Cleared to 0 on every new grant, including a re-grant to the same index.
  - Increments by 1 each BUSY cycle without R.
  - Width is $clog2(MAX_HOLD+1). It never wraps, because it is cleared at MAX_HOLD-1.
  - With MAX_HOLD=N, a holder keeps the grant for at most N consecutive cycles per tenure.
- timeout:
  - Asserted for exactly one cycle after an edge where the release was caused only by the counter.
  - If done[h]=1 or req[h]=0 in the same cycle as counter expiry, the release counts as normal and timeout=0.
  - After a forced release, the preempted requester may be re-granted immediately if no other req is pending. This starts a new tenure with counter=0.
- done bits of non-holders, and all done bits in IDLE, are ignored.
- req rising on other requesters during a tenure does not disturb the holder.
- grant is never multi-hot; grant_id is always consistent with grant.

Test Plan:
- Reset, then req=4'b1111 held, done=0, MAX_HOLD=4.
  - Required: grant 0001 for 4 cycles, then 0010×4, 0100×4, 1000×4, then 0001.
  - timeout pulses once per handover; no idle cycles between grants.
- req=4'b0100 only.
  - Required: grant=0100 one cycle later.
  - done[2] pulse → grant=0 next edge, state IDLE, timeout=0.
  - Keep req[2]=1 → re-granted after one IDLE cycle.
- Single requester req=4'b0001 held, MAX_HOLD=4.
  - Required: grant stays 0001 continuously.
  - timeout pulses every 4 cycles; grant_valid never drops.
- Holder 1 drops req[1] while req[3] and req[0] are pending, ptr=2.
  - Required: next edge grant=1000, grant_id=3; the following release goes to 0001.
- Simultaneous done[h] and counter expiry.
  - Required: release occurs, timeout=0.
  - Separately, done on a non-holder has no effect on grant.
- rst=1 asserted mid-tenure with grant=0100.
  - Required: the same edge gives grant=0, counter=0.
  - After release of rst with req=1111, first grant=0001.

Source files
------------

// File: rtl/arb_rr_hold.sv
// arb_rr_hold -- round-robin arbiter with multi-cycle grant tenure.
//
// Shares one downstream resource among REQ_NUM requesters. A granted
// requester keeps the grant until it drops req, pulses done, or (when
// MAX_HOLD != 0) has held it for MAX_HOLD cycles and is preempted.
// Re-arbitration happens on the releasing edge itself, so a handover
// between requesters has no idle bubble.
//
// Parameters:
//   REQ_NUM   number of requesters (2..16)
//   MAX_HOLD  maximum tenure in cycles; 0 disables the forced release
//   ID_W      width of grant_id, derived from REQ_NUM
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   req          per-requester request level
//   done         per-requester one-cycle release pulse (holder bit only)
//   grant        registered one-hot grant, or all-zero
//   grant_valid  high when grant is non-zero
//   grant_id     index of the holder, 0 when no grant
//   timeout      one-cycle pulse after a release forced by the hold limit
module arb_rr_hold #(
  parameter int unsigned REQ_NUM  = 4,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned ID_W    = $clog2(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req,
  input  logic [REQ_NUM-1:0] done,
  output logic [REQ_NUM-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout
);

  // Counter must hold 0..MAX_HOLD-1; keep at least one bit when the
  // timeout is disabled so the declaration stays legal.
  localparam int unsigned CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0] ID_LAST  = ID_W'(REQ_NUM - 1);
  localparam bit              TO_EN    = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e             state_q;
  logic [REQ_NUM-1:0] grant_q;
  logic               grant_valid_q;
  logic [ID_W-1:0]    grant_id_q;
  logic               timeout_q;
  logic [ID_W-1:0]    ptr_q;
  logic [CW-1:0]      cnt_q;

  logic               hold_req;
  logic               hold_done;
  logic               expire;
  logic               release_c;
  logic               arb_en;
  logic               forced;
  logic [REQ_NUM-1:0] cand;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    ptr_d;
  logic [REQ_NUM-1:0] grant_d;

  // Release evaluation for the current holder. In IDLE grant_id_q is 0 and
  // these terms are don't-care because arbitration is always enabled there.
  always_comb begin
    hold_req  = req[grant_id_q];
    hold_done = done[grant_id_q];
    expire    = TO_EN && (cnt_q == CNT_LAST);
    release_c = !hold_req || hold_done || expire;
    arb_en    = (state_q == IDLE) || release_c;
    // Only a pure hold-limit release reports a timeout.
    forced    = (state_q == BUSY) && expire && hold_req && !hold_done;
    // A holder that signalled done may not win the same re-arbitration.
    cand      = req;
    if ((state_q == BUSY) && hold_done) begin
      cand[grant_id_q] = 1'b0;
    end
  end

  // Round-robin search: first set candidate at or above ptr, wrapping.
  // Because ptr moves past every winner, a continuing holder is searched
  // last and any other pending requester takes over first.
  always_comb begin
    int unsigned       idx;
    logic [ID_W-1:0]   idx_w;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= REQ_NUM) begin
        idx = idx - REQ_NUM;
      end
      idx_w = ID_W'(idx);
      if (!win_found && cand[idx_w]) begin
        win_found = 1'b1;
        win_id    = idx_w;
      end
    end
    ptr_d   = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
    grant_d = REQ_NUM'(1) << win_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
      cnt_q         <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (arb_en) begin
        timeout_q <= forced;
        cnt_q     <= '0;
        if (win_found) begin
          state_q       <= BUSY;
          grant_q       <= grant_d;
          grant_valid_q <= 1'b1;
          grant_id_q    <= win_id;
          ptr_q         <= ptr_d;
        end else begin
          state_q       <= IDLE;
          grant_q       <= '0;
          grant_valid_q <= 1'b0;
          grant_id_q    <= '0;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout     = timeout_q;

endmodule
